// File: rtl/nested_isqrt_pkg.sv
// Shared latency helpers and overflow policy encoding for the nested isqrt chain.
package nested_isqrt_pkg;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_policy_e;

  function automatic int unsigned isq_lat(input int unsigned width);
    return width / 2;
  endfunction

  function automatic int unsigned chain_lat(input int unsigned width, input int unsigned levels);
    return levels * isq_lat(width) + (levels - 1);
  endfunction

endpackage

// File: rtl/isqrt_pipe_n.sv
// Bit-per-stage restoring floor square root, one result bit resolved per pipeline stage.
module isqrt_pipe_n #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_vld,
  input  logic [WIDTH-1:0]   x,
  output logic               y_vld,
  output logic [WIDTH/2-1:0] y
);

  localparam int unsigned H = WIDTH / 2;

  logic             vld_q  [H];
  logic [H-1:0]     rem_q  [H];
  logic [H-1:0]     root_q [H];
  logic [WIDTH-1:0] x_q    [H];

  for (genvar s = 0; s < H; s++) begin : g_stage
    logic             in_vld;
    logic [H-1:0]     rem_in;
    logic [H-2:0]     root_in;
    logic [WIDTH-1:0] x_in;
    logic [H+1:0]     cand;
    logic [H+1:0]     trial;
    logic             ge;

    if (s == 0) begin : g_first
      assign in_vld  = x_vld;
      assign rem_in  = '0;
      assign root_in = '0;
      assign x_in    = x;
    end else begin : g_next
      assign in_vld  = vld_q[s-1];
      assign rem_in  = rem_q[s-1];
      assign root_in = root_q[s-1][H-2:0];
      assign x_in    = x_q[s-1];
    end

    // Bring down the next two radicand bits and try root*4+1 against the remainder.
    assign cand  = {rem_in, x_in[WIDTH-1 -: 2]};
    assign trial = {1'b0, root_in, 2'b01};
    assign ge    = (cand >= trial);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[s] <= 1'b0;
      end else begin
        vld_q[s] <= in_vld;
      end
    end

    always_ff @(posedge clk) begin
      if (in_vld) begin
        rem_q[s]  <= H'(ge ? cand - trial : cand);
        root_q[s] <= {root_in, ge};
        x_q[s]    <= {x_in[WIDTH-3:0], 2'b00};
      end
    end
  end

  assign y_vld = vld_q[H-1];
  assign y     = root_q[H-1];

endmodule

// File: rtl/nested_isqrt_chain_pipe.sv
// Fully pipelined y = isqrt(x0 + isqrt(x1 + ... + isqrt(x[LEVELS-1]))) with overflow tracking.
module nested_isqrt_chain_pipe
  import nested_isqrt_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LEVELS   = 3,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            arg_vld,
  input  logic [LEVELS*WIDTH-1:0]                         x,
  output logic                                            res_vld,
  output logic [WIDTH-1:0]                                res,
  output logic                                            res_ovf,
  output logic                                            busy,
  output logic [$clog2(chain_lat(WIDTH, LEVELS)+1)-1:0]   occupancy
);

  localparam int unsigned H   = isq_lat(WIDTH);
  localparam int unsigned LAT = chain_lat(WIDTH, LEVELS);
  localparam int unsigned OW  = $clog2(LAT + 1);
  localparam ovf_policy_e Policy = SATURATE ? OVF_SAT : OVF_WRAP;

  logic             lvl_vld [LEVELS];
  logic [WIDTH-1:0] lvl_x   [LEVELS];
  logic             y_vld   [LEVELS];
  logic [H-1:0]     y       [LEVELS];
  logic             y_ovf   [LEVELS];

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    isqrt_pipe_n #(
      .WIDTH(WIDTH)
    ) u_isqrt (
      .clk  (clk),
      .rst_n(rst_n),
      .x_vld(lvl_vld[k]),
      .x    (lvl_x[k]),
      .y_vld(y_vld[k]),
      .y    (y[k])
    );

    if (k == LEVELS - 1) begin : g_inner
      assign lvl_vld[k] = arg_vld;
      assign lvl_x[k]   = x[k*WIDTH +: WIDTH];
      assign y_ovf[k]   = 1'b0;
    end else begin : g_outer
      // The sum register is the final stage of xk's delay, so the line itself is one shorter.
      localparam int unsigned D = (LEVELS - 1 - k) * (H + 1) - 1;

      logic             dl_vld_q [D];
      logic [WIDTH-1:0] dl_q     [D];
      logic [WIDTH:0]   add;
      logic             sum_vld_q;
      logic             sum_ovf_q;
      logic [WIDTH-1:0] sum_q;
      logic [H-1:0]     ovf_line_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < D; d++) dl_vld_q[d] <= 1'b0;
        end else begin
          dl_vld_q[0] <= arg_vld;
          for (int d = 1; d < D; d++) dl_vld_q[d] <= dl_vld_q[d-1];
        end
      end

      always_ff @(posedge clk) begin
        if (arg_vld) dl_q[0] <= x[k*WIDTH +: WIDTH];
        for (int d = 1; d < D; d++) begin
          if (dl_vld_q[d-1]) dl_q[d] <= dl_q[d-1];
        end
      end

      assign add = {1'b0, {(WIDTH-H){1'b0}}, y[k+1]} + {1'b0, dl_q[D-1]};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_vld_q  <= 1'b0;
          sum_ovf_q  <= 1'b0;
          ovf_line_q <= '0;
        end else begin
          sum_vld_q  <= y_vld[k+1];
          sum_ovf_q  <= y_vld[k+1] & (add[WIDTH] | y_ovf[k+1]);
          // Sticky flag rides alongside the isqrt stages; bubbles carry 0.
          ovf_line_q <= {ovf_line_q[H-2:0], sum_ovf_q};
        end
      end

      always_ff @(posedge clk) begin
        if (y_vld[k+1]) begin
          sum_q <= (Policy == OVF_SAT && add[WIDTH]) ? '1 : add[WIDTH-1:0];
        end
      end

      assign lvl_vld[k] = sum_vld_q;
      assign lvl_x[k]   = sum_q;
      assign y_ovf[k]   = ovf_line_q[H-1];
    end
  end

  logic [OW-1:0] occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (arg_vld && !res_vld) begin
      occ_q <= occ_q + 1'b1;
    end else if (!arg_vld && res_vld) begin
      occ_q <= occ_q - 1'b1;
    end
  end

  assign res_vld   = y_vld[0];
  assign res       = {{(WIDTH-H){1'b0}}, y[0]};
  assign res_ovf   = res_vld & y_ovf[0];
  assign occupancy = occ_q;
  assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_nested_isqrt_chain_pipe.sv
// Checks three chain configurations cycle by cycle against an arithmetic reference model.
module tb_nested_isqrt_chain_pipe;

  localparam int NC = 2048;

  logic        clk;
  logic        rst_n;

  logic        arg_vld_a, res_vld_a, res_ovf_a, busy_a;
  logic [95:0] x_a;
  logic [31:0] res_a;
  logic [5:0]  occ_a;

  logic        arg_vld_b, res_vld_b, res_ovf_b, busy_b;
  logic [79:0] x_b;
  logic [15:0] res_b;
  logic [5:0]  occ_b;

  logic        arg_vld_c, res_vld_c, res_ovf_c, busy_c;
  logic [7:0]  x_c;
  logic [7:0]  res_c;
  logic [2:0]  occ_c;

  nested_isqrt_chain_pipe #(.WIDTH(32), .LEVELS(3), .SATURATE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld_a), .x(x_a), .res_vld(res_vld_a),
    .res(res_a), .res_ovf(res_ovf_a), .busy(busy_a), .occupancy(occ_a)
  );

  nested_isqrt_chain_pipe #(.WIDTH(16), .LEVELS(5), .SATURATE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld_b), .x(x_b), .res_vld(res_vld_b),
    .res(res_b), .res_ovf(res_ovf_b), .busy(busy_b), .occupancy(occ_b)
  );

  nested_isqrt_chain_pipe #(.WIDTH(8), .LEVELS(1), .SATURATE(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld_c), .x(x_c), .res_vld(res_vld_c),
    .res(res_c), .res_ovf(res_ovf_c), .busy(busy_c), .occupancy(occ_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat  [3] = '{50, 44, 4};
  int          wid  [3] = '{32, 16, 8};
  int          lvls [3] = '{3, 5, 1};
  bit          sat  [3] = '{1'b1, 1'b0, 1'b1};
  bit          ev   [3][NC];
  bit [31:0]   er   [3][NC];
  bit          eo   [3][NC];
  int          occ_m [3];
  bit          va, vb, vc;
  bit [31:0]   xa [5];
  bit [31:0]   xb [5];
  bit [31:0]   xc [5];

  function automatic longint unsigned isqrt_m(input longint unsigned v);
    longint unsigned lo = 0;
    longint unsigned hi = 65536;
    while (hi - lo > 1) begin
      longint unsigned mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // {ovf, result} of the nested formula with wrap or clamp on each inner add.
  function automatic bit [32:0] nest_m(input bit [31:0] xs [5], input int w, input int lv,
                                       input bit sa);
    longint unsigned lim = longint'(1) << w;
    longint unsigned acc = isqrt_m(longint'(xs[lv-1]));
    bit              ovf = 1'b0;
    for (int k = lv - 2; k >= 0; k--) begin
      longint unsigned s = acc + longint'(xs[k]);
      if (s >= lim) begin
        ovf = 1'b1;
        s   = sa ? lim - 1 : s - lim;
      end
      acc = isqrt_m(s);
    end
    return {ovf, acc[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_assert++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: got %0h, want %0h", tag, cyc, got, want);
    end
  endtask

  task automatic chk_dut(input int d, input logic v, input logic [31:0] r, input logic o,
                         input logic [7:0] occ, input logic b);
    check($sformatf("res_vld[%0d]", d), 64'(v), 64'(ev[d][cyc]));
    if (ev[d][cyc]) begin
      check($sformatf("res[%0d]", d), 64'(r), 64'(er[d][cyc]));
      check($sformatf("res_ovf[%0d]", d), 64'(o), 64'(eo[d][cyc]));
    end else begin
      check($sformatf("res_ovf_idle[%0d]", d), 64'(o), 64'd0);
    end
    check($sformatf("occupancy[%0d]", d), 64'(occ), 64'(occ_m[d]));
    check($sformatf("busy[%0d]", d), 64'(b), 64'(occ_m[d] != 0));
  endtask

  task automatic record(input int d, input bit v, input bit [31:0] xs [5], output int occ_n);
    bit acc = v & rst_n;
    if (acc) begin
      bit [32:0] m = nest_m(xs, wid[d], lvls[d], sat[d]);
      ev[d][cyc+lat[d]] = 1'b1;
      er[d][cyc+lat[d]] = m[31:0];
      eo[d][cyc+lat[d]] = m[32];
    end
    occ_n = rst_n ? occ_m[d] + int'(acc) - int'(ev[d][cyc]) : 0;
  endtask

  // Drive the staged inputs for the current cycle, advance one clock and check every output.
  task automatic clk_cycle();
    int on [3];
    arg_vld_a = va;
    x_a       = {xa[2], xa[1], xa[0]};
    arg_vld_b = vb;
    x_b       = {xb[4][15:0], xb[3][15:0], xb[2][15:0], xb[1][15:0], xb[0][15:0]};
    arg_vld_c = vc;
    x_c       = xc[0][7:0];
    record(0, va, xa, on[0]);
    record(1, vb, xb, on[1]);
    record(2, vc, xc, on[2]);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) occ_m[d] = on[d];
    chk_dut(0, res_vld_a, res_a, res_ovf_a, 8'(occ_a), busy_a);
    chk_dut(1, res_vld_b, 32'(res_b), res_ovf_b, 8'(occ_b), busy_b);
    chk_dut(2, res_vld_c, 32'(res_c), res_ovf_c, 8'(occ_c), busy_c);
  endtask

  task automatic idle(input int n);
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    repeat (n) clk_cycle();
  endtask

  task automatic rand_sets(input int density);
    va = ($urandom_range(0, 99) < density);
    vb = ($urandom_range(0, 99) < density);
    vc = ($urandom_range(0, 99) < density);
    for (int k = 0; k < 5; k++) begin
      xa[k] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                          : $urandom;
      xb[k] = 32'($urandom_range(0, 65535));
      xc[k] = 32'($urandom_range(0, 255));
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      occ_m[d] = 0;
      for (int i = cyc; i < NC; i++) ev[d][i] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    logic [31:0] hold_a;
    logic [15:0] hold_b;
    logic [7:0]  hold_c;

    for (int d = 0; d < 3; d++) begin
      occ_m[d] = 0;
      for (int i = 0; i < NC; i++) begin
        ev[d][i] = 1'b0; er[d][i] = '0; eo[d][i] = 1'b0;
      end
    end
    for (int k = 0; k < 5; k++) begin
      xa[k] = '0; xb[k] = '0; xc[k] = '0;
    end
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    rst_n = 1'b0;
    #1;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single directed transaction through the 3-level chain.
    xa[0] = 32'd20; xa[1] = 32'd16; xa[2] = 32'd81;
    va = 1'b1;
    c0 = cyc;
    clk_cycle();
    idle(49);
    check("t1_vld_at_lat", 64'(res_vld_a), 64'd1);
    check("t1_res", 64'(res_a), 64'd5);
    check("t1_ovf", 64'(res_ovf_a), 64'd0);
    idle(3);

    // Overflow under both policies, then a clean set right behind it.
    xa[0] = 32'hFFFF_FFFF; xa[1] = 32'd0; xa[2] = 32'd1;
    xb[0] = 32'h0000_FFFF; xb[1] = 32'd0; xb[2] = 32'd0; xb[3] = 32'd0; xb[4] = 32'd1;
    xc[0] = 32'd200;
    va = 1'b1; vb = 1'b1; vc = 1'b1;
    c0 = cyc;
    clk_cycle();
    xa[0] = 32'd20; xa[1] = 32'd16; xa[2] = 32'd81;
    xb[0] = 32'd3; xb[4] = 32'd16;
    vc = 1'b0;
    clk_cycle();
    va = 1'b0; vb = 1'b0;
    for (int i = 0; i < 52; i++) begin
      clk_cycle();
      if (cyc == c0 + 4) begin
        check("t3_c_res", 64'(res_c), 64'd14);
        check("t3_c_ovf", 64'(res_ovf_c), 64'd0);
      end
      if (cyc == c0 + 44) begin
        check("t3_b_wrap_res", 64'(res_b), 64'd0);
        check("t3_b_wrap_ovf", 64'(res_ovf_b), 64'd1);
      end
      if (cyc == c0 + 50) begin
        check("t3_a_sat_res", 64'(res_a), 64'd65535);
        check("t3_a_sat_ovf", 64'(res_ovf_a), 64'd1);
      end
      if (cyc == c0 + 51) begin
        check("t3_a_next_ovf", 64'(res_ovf_a), 64'd0);
        check("t3_a_next_res", 64'(res_a), 64'd5);
      end
    end
    idle(2);

    // Random stream with bubbles on all three configurations.
    for (int n = 0; n < 200; n++) begin
      rand_sets(70);
      clk_cycle();
    end
    idle(55);

    // Reset in the middle of a back-to-back burst.
    c0 = cyc;
    for (int n = 0; n < 10; n++) begin
      rand_sets(100);
      clk_cycle();
    end
    idle(10);
    assert_reset();
    idle(2);
    rst_n = 1'b1;
    idle(2);
    xa[0] = 32'd0; xa[1] = 32'd0; xa[2] = 32'd49;
    va = 1'b1;
    c0 = cyc;
    clk_cycle();
    idle(49);
    check("t4_vld_after_reset", 64'(res_vld_a), 64'd1);
    check("t4_res_after_reset", 64'(res_a), 64'd1);
    idle(3);

    // Idle inputs toggling: outputs must hold and never signal valid.
    hold_a = res_a;
    hold_b = res_b;
    hold_c = res_c;
    for (int n = 0; n < 100; n++) begin
      rand_sets(0);
      clk_cycle();
      check("t6_res_a_hold", 64'(res_a), 64'(hold_a));
      check("t6_res_b_hold", 64'(res_b), 64'(hold_b));
      check("t6_res_c_hold", 64'(res_c), 64'(hold_c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
